// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter feeding a 3-to-8 decoder (grant_idx -> In, grant_valid -> enable).
// Latency 1 clock request-to-grant; grants held until released (or HOLD_LIMIT reached when RR_ARB_TIMEOUT_EN is defined).
module rr_arbiter8 #(
  parameter int unsigned HOLD_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       timeout_pulse
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] search_from;
  logic [2:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       timeout;
  logic       rearb;
  logic       take;

  // First requester found walking start, start+1, ... start+7 (mod 8).
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] w;
    w = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  assign any_req     = |req;
  assign owner_req   = req[grant_idx];
  assign search_from = (state == IDLE) ? ptr : grant_idx + 3'd1;
  assign winner      = pick(req, search_from);
  assign rearb       = (state == GRANT) && (!owner_req || timeout);
  assign take        = any_req && ((state == IDLE) || rearb);

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] LIMIT_M1 = 8'(HOLD_LIMIT - 1);

  logic [7:0] hold_cnt;

  assign timeout = (state == GRANT) && owner_req && (hold_cnt >= LIMIT_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt      <= 8'd0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout;
      if (take)
        hold_cnt <= 8'd0;
      else if ((state == GRANT) && (hold_cnt != 8'hFF))
        hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  // HOLD_LIMIT has no effect in this build.
  logic unused_hold_limit;
  assign unused_hold_limit = ^8'(HOLD_LIMIT);
  assign timeout           = 1'b0;
  assign timeout_pulse     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= 3'd0;
      ptr         <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_idx   <= winner;
          end
        end
        GRANT: begin
          if (rearb) begin
            ptr <= grant_idx + 3'd1;
            if (any_req) begin
              grant_idx <= winner;
            end else begin
              state       <= IDLE;
              grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table plus hand sequences, scoreboard queue of expected outputs.
`timescale 1ns/1ps
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       timeout_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
    logic       pulse;
  } exp_t;

  typedef struct {
    bit         rst;
    logic [7:0] req;
    exp_t       exp;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  rr_arbiter8 #(.HOLD_LIMIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge: drive req, expect the outputs after the next rising edge.
  task automatic step(input logic [7:0] r, input logic v, input logic [2:0] i, input logic p, input string name);
    exp_t e;
    exp_t got;
    req = r;
    sb.push_back('{vld: v, idx: i, pulse: p});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    got = '{vld: grant_valid, idx: grant_idx, pulse: timeout_pulse};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got vld=%0b idx=%0d pulse=%0b, want vld=%0b idx=%0d pulse=%0b",
               name, got.vld, got.idx, got.pulse, e.vld, e.idx, e.pulse);
    end
    @(negedge clk);
  endtask

  // Ends at a falling edge with reset released.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    checks++;
    if ({grant_valid, grant_idx, timeout_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL %s: got vld=%0b idx=%0d pulse=%0b, want all zero",
               name, grant_valid, grant_idx, timeout_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h08, '{1'b1, 3'd3, 1'b0}, "single_grant3"};
    tbl[1] = '{1'b0, 8'h08, '{1'b1, 3'd3, 1'b0}, "single_hold3"};
    tbl[2] = '{1'b0, 8'h00, '{1'b0, 3'd3, 1'b0}, "single_release"};
    tbl[3] = '{1'b0, 8'h00, '{1'b0, 3'd3, 1'b0}, "idle_keeps_idx"};
    tbl[4] = '{1'b1, 8'h81, '{1'b1, 3'd0, 1'b0}, "wrap_grant0"};
    tbl[5] = '{1'b0, 8'h80, '{1'b1, 3'd7, 1'b0}, "wrap_grant7"};
    tbl[6] = '{1'b0, 8'h01, '{1'b1, 3'd0, 1'b0}, "wrap_grant0_again"};
    tbl[7] = '{1'b0, 8'h00, '{1'b0, 3'd0, 1'b0}, "wrap_idle"};

    for (int n = 0; n < 8; n++) begin
      if (tbl[n].rst) do_reset("reset_outputs");
      step(tbl[n].req, tbl[n].exp.vld, tbl[n].exp.idx, tbl[n].exp.pulse, tbl[n].name);
    end

    // Rotation: every owner holds two cycles then releases; no bubble between owners.
    do_reset("reset_rotation");
    step(8'hFF, 1'b1, 3'd0, 1'b0, "rot_first");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] rel;
      rel = 8'hFF & ~(8'h01 << i);
      step(8'hFF, 1'b1, 3'(i), 1'b0, "rot_hold");
      step(rel, 1'b1, 3'(i + 1), 1'b0, "rot_handoff");
    end
    step(8'h00, 1'b0, 3'd0, 1'b0, "rot_idle");

`ifndef RR_ARB_TIMEOUT_EN
    // ptr is now 1, so 2 wins over 5; 5 must not preempt.
    step(8'h24, 1'b1, 3'd2, 1'b0, "nopre_grant2");
    for (int c = 0; c < 40; c++) step(8'h24, 1'b1, 3'd2, 1'b0, "nopre_hold2");
    step(8'h20, 1'b1, 3'd5, 1'b0, "nopre_grant5");
    step(8'h00, 1'b0, 3'd5, 1'b0, "nopre_idle");
`else
    do_reset("reset_timeout");
    for (int c = 0; c < 4; c++) step(8'h03, 1'b1, 3'd0, 1'b0, "to_hold0");
    step(8'h03, 1'b1, 3'd1, 1'b1, "to_preempt0");
    for (int c = 0; c < 3; c++) step(8'h03, 1'b1, 3'd1, 1'b0, "to_hold1");
    step(8'h03, 1'b1, 3'd0, 1'b1, "to_preempt1");
    for (int c = 0; c < 3; c++) step(8'h01, 1'b1, 3'd0, 1'b0, "to_sole_hold");
    step(8'h01, 1'b1, 3'd0, 1'b1, "to_sole_regrant");
    step(8'h01, 1'b1, 3'd0, 1'b0, "to_sole_restart");
    step(8'h00, 1'b0, 3'd0, 1'b0, "to_idle");
`endif

    // Async reset in the middle of a grant to requester 6.
    do_reset("reset_async");
    step(8'h40, 1'b1, 3'd6, 1'b0, "async_grant6");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL async_drop: got vld=%0b idx=%0d, want vld=0 idx=0", grant_valid, grant_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h40, 1'b1, 3'd6, 1'b0, "async_regrant6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
